// File: rtl/ready_arbiter.sv
// ready_arbiter: round-robin arbiter for one single-owner resource shared by N
// requesters over a req/grant/done handshake. A per-grant watchdog revokes a
// grant whose owner never signals completion. Every grant is followed by a
// one-cycle RELEASE state, so grants are separated by at least two idle cycles.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req[N]        request levels, held high while waiting
//   done[N]       completion strobes; only the current owner's bit is honoured
//   grant[N]      one-hot grant, zero when the resource is free
//   grant_id      index of the current or most recent owner
//   busy          high while a grant is held
//   timeout_pulse one-cycle pulse after a watchdog revocation
//   grant_count   number of grants issued, modulo 2^16
module ready_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout_pulse,
    output logic [15:0]          grant_count
);

    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned TW  = 8;
    localparam int unsigned CW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e          state_q,         state_d;
    logic [N-1:0]    grant_q,         grant_d;
    logic [IDW-1:0]  grant_id_q,      grant_id_d;
    logic            busy_q,          busy_d;
    logic            timeout_pulse_q, timeout_pulse_d;
    logic [CW-1:0]   grant_count_q,   grant_count_d;
    logic [TW-1:0]   timer_q,         timer_d;

    logic            sel_found_c;
    logic [IDW-1:0]  sel_id_c;
    logic [IDW-1:0]  scan_id_c;
    logic            owner_done_c;
    logic            timer_expired_c;

    // Round-robin pick: first requester after the last owner, wrapping modulo N.
    always_comb begin
        sel_found_c = 1'b0;
        sel_id_c    = '0;
        scan_id_c   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            scan_id_c = IDW'((32'(grant_id_q) + i) % N);
            if (!sel_found_c && req[scan_id_c]) begin
                sel_found_c = 1'b1;
                sel_id_c    = scan_id_c;
            end
        end
    end

    // Only the owner's done bit counts; other requesters cannot end a grant.
    assign owner_done_c    = done[grant_id_q];
    assign timer_expired_c = (timer_q == TW'(TIMEOUT - 1));

    // Next-state and registered-output computation.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        grant_id_d      = grant_id_q;
        busy_d          = busy_q;
        timeout_pulse_d = 1'b0;
        grant_count_d   = grant_count_q;
        timer_d         = timer_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (sel_found_c) begin
                    grant_d       = {{(N-1){1'b0}}, 1'b1} << sel_id_c;
                    grant_id_d    = sel_id_c;
                    busy_d        = 1'b1;
                    timer_d       = '0;
                    grant_count_d = grant_count_q + CW'(1);
                    state_d       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // done has priority over an expiry on the same edge
                if (owner_done_c) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = ST_RELEASE;
                end else if (timer_expired_c) begin
                    grant_d         = '0;
                    busy_d          = 1'b0;
                    timeout_pulse_d = 1'b1;
                    state_d         = ST_RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks priority so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            grant_id_q      <= IDW'(N - 1);
            busy_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
            grant_count_q   <= '0;
            timer_q         <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            grant_id_q      <= grant_id_d;
            busy_q          <= busy_d;
            timeout_pulse_q <= timeout_pulse_d;
            grant_count_q   <= grant_count_d;
            timer_q         <= timer_d;
        end
    end

    assign grant         = grant_q;
    assign grant_id      = grant_id_q;
    assign busy          = busy_q;
    assign timeout_pulse = timeout_pulse_q;
    assign grant_count   = grant_count_q;

endmodule
